// File: rtl/mem_responder_if.sv
// Request/response bundle between the multicycle controller and mem_responder.
// The controller side uses the master modport, the memory uses slave.
interface mem_responder_if;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [1:0]  mem_size;
   logic [31:0] read_data;
   logic        mem_ready;
   logic        mem_err;
   logic        busy;

   modport master (
      output mem_read, mem_write, addr, write_data, mem_size,
      input  read_data, mem_ready, mem_err, busy
   );

   modport slave (
      input  mem_read, mem_write, addr, write_data, mem_size,
      output read_data, mem_ready, mem_err, busy
   );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory for the multicycle controller.
// A request (mem_read/mem_write) is latched in IDLE, held for WAIT_CYCLES wait
// states, and answered with a one-cycle mem_ready pulse. Loads are zero-extended
// and right-aligned; byte/half stores merge into the addressed lanes only.
//
// Optional build macro: MEM_ERR_EN
//   defined   : misaligned, out-of-range, reserved-size and read+write requests
//               are flagged on mem_err; such requests never write the array and
//               return read_data = 0.
//   undefined : mem_err is tied low, addresses wrap modulo DEPTH_WORDS and
//               misaligned low address bits are ignored.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no request in flight; a high mem_read/mem_write is accepted
// ST_WAIT | counting down the wait states; inputs are ignored
// ST_RESP | mem_ready high for one cycle; stores commit on the edge leaving
module mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [1:0]  size_q;
   logic        rd_q;
   logic        wr_q;
   logic [31:0] read_data_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic             req;
   logic             accept;
   logic             enter_resp;
   logic             do_write;
   logic [31:0]      acc_addr;
   logic [1:0]       acc_size;
   logic             acc_rd;
   logic [IDX_W-1:0] acc_idx;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      rd_word;
   logic [31:0]      old_word;
   logic [31:0]      load_data;
   logic [31:0]      merged;

   assign req    = bus.mem_read | bus.mem_write;
   assign accept = (state_q == ST_IDLE) && req;

   // The access that is about to enter RESP comes straight from the bus when
   // there are no wait states (IDLE -> RESP), otherwise from the latched copy.
   assign acc_addr = (state_q == ST_IDLE) ? bus.addr     : addr_q;
   assign acc_size = (state_q == ST_IDLE) ? bus.mem_size : size_q;
   assign acc_rd   = (state_q == ST_IDLE) ? bus.mem_read : rd_q;

   assign acc_idx  = acc_addr[IDX_W+1:2];
   assign wr_idx   = addr_q[IDX_W+1:2];
   assign rd_word  = mem[acc_idx];
   assign old_word = mem[wr_idx];

   assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

   // State register and wait-state down-counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; WAIT leaves on terminal count zero.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture the request when it is accepted in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else if (accept) begin
         addr_q  <= bus.addr;
         wdata_q <= bus.write_data;
         size_q  <= bus.mem_size;
         rd_q    <= bus.mem_read;
         wr_q    <= bus.mem_write;
      end
   end

   // Load alignment: pick the lane(s) and zero-extend; reserved size acts as word.
   always_comb begin
      load_data = rd_word;
      case (acc_size)
         SZ_BYTE: load_data = {24'h0, rd_word[{acc_addr[1:0], 3'b000} +: 8]};
         SZ_HALF: load_data = acc_addr[1] ? {16'h0, rd_word[31:16]}
                                          : {16'h0, rd_word[15:0]};
         default: load_data = rd_word;
      endcase
   end

   // Store merge: only the addressed lanes take the right-aligned store data.
   always_comb begin
      merged = old_word;
      case (size_q)
         SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         SZ_HALF: begin
            if (addr_q[1]) begin
               merged[31:16] = wdata_q[15:0];
            end else begin
               merged[15:0] = wdata_q[15:0];
            end
         end
         default: merged = wdata_q;
      endcase
   end

`ifdef MEM_ERR_EN
   logic acc_wr;
   logic acc_err;
   logic err_q;

   assign acc_wr  = (state_q == ST_IDLE) ? bus.mem_write : wr_q;
   assign acc_err = ((acc_size == SZ_HALF) && acc_addr[0])
                 || ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00))
                 || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS))
                 || (acc_size == 2'b11)
                 || (acc_rd && acc_wr);

   // Error flag is decided on the edge entering RESP, alongside read_data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (enter_resp) begin
         err_q <= acc_err;
      end
   end

   // Read data: zero on an error response, otherwise updated by reads only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data_q <= '0;
      end else if (enter_resp) begin
         if (acc_err) begin
            read_data_q <= '0;
         end else if (acc_rd) begin
            read_data_q <= load_data;
         end
      end
   end

   assign do_write    = (state_q == ST_RESP) && wr_q && !rd_q && !err_q;
   assign bus.mem_err = (state_q == ST_RESP) && err_q;
`else
   logic unused_hi_addr;
   assign unused_hi_addr = ^acc_addr[31:IDX_W+2];

   // Read data is updated by reads only; writes leave it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         read_data_q <= '0;
      end else if (enter_resp && acc_rd) begin
         read_data_q <= load_data;
      end
   end

   // A simultaneous read+write performs the read and drops the write.
   assign do_write    = (state_q == ST_RESP) && wr_q && !rd_q;
   assign bus.mem_err = 1'b0;
`endif

   // Array update on the edge leaving RESP; contents survive reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[wr_idx] <= merged;
      end
   end

   assign bus.read_data = read_data_q;
   assign bus.mem_ready = (state_q == ST_RESP);
   assign bus.busy      = (state_q != ST_IDLE);

endmodule
